// File: rtl/cpu_pkg.sv
// Shared opcodes, phase encoding and instruction field positions for the
// 16-bit multi-cycle CPU.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_IN   = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } phase_t;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 9;
  localparam int RS_MSB = 8;
  localparam int RS_LSB = 6;
  localparam int RT_MSB = 5;
  localparam int RT_LSB = 3;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

endpackage

// File: rtl/cpu_top_alu.sv
// Combinational 16-bit ALU; LD/ST/ADDI share the adder for address and
// immediate arithmetic, LDI passes the immediate operand through.
module alu16
  import cpu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  // Operation select; anything not listed resolves to the adder
  always_comb begin
    y = 16'h0000;
    case (op)
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_LDI:  y = b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/cpu_top.sv
// Minimal non-pipelined 16-bit CPU: every instruction walks
// FETCH, DECODE, EXECUTE, MEM, WB in five cycles.
module cpu_top
  import cpu_pkg::*;
#(
  parameter int    DMEM_DEPTH = 16,
  parameter int    PMEM_DEPTH = 256,
  parameter string PROG_FILE  = ""
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  localparam int AW = $clog2(DMEM_DEPTH);
  localparam int PW = $clog2(PMEM_DEPTH);

  logic [15:0] prog_mem [0:PMEM_DEPTH-1];
  logic [15:0] data_mem [0:DMEM_DEPTH-1];
  logic [15:0] rf_r [0:7];

  phase_t        phase_r, phase_nxt_s;
  logic [PW-1:0] pc_r, pc_nxt_s;
  logic [15:0]   ir_r, a_r, b_r, d_r, alu_r, mdr_r, dout_r;
  logic [15:0]   alu_b_s, alu_y_s, rf_wdata_s;
  logic [3:0]    op_s;
  logic [2:0]    rd_s, rs_s, rt_s;
  logic          rf_we_s;
  logic [AW-1:0] addr_s;

  // Program ROM image; memories are deliberately outside the reset domain
  initial begin
    for (int i = 0; i < PMEM_DEPTH; i++) prog_mem[i] = 16'h0000;
  end

  assign op_s   = ir_r[OP_MSB:OP_LSB];
  assign rd_s   = ir_r[RD_MSB:RD_LSB];
  assign rs_s   = ir_r[RS_MSB:RS_LSB];
  assign rt_s   = ir_r[RT_MSB:RT_LSB];
  assign addr_s = alu_r[AW-1:0];
  assign dout   = dout_r;

  // Second ALU operand: register rt or the instruction immediate
  always_comb begin
    alu_b_s = b_r;
    case (op_s)
      OP_ADDI, OP_LD, OP_ST: alu_b_s = sext6(ir_r[5:0]);
      OP_LDI:                alu_b_s = {7'd0, ir_r[8:0]};
      default:               alu_b_s = b_r;
    endcase
  end

  alu16 u_alu (
    .op (op_s),
    .a  (a_r),
    .b  (alu_b_s),
    .y  (alu_y_s)
  );

  // Phase sequencing plus write-back selection and next-PC computation
  always_comb begin
    phase_nxt_s = phase_r;
    pc_nxt_s    = pc_r + PW'(1);
    rf_we_s     = 1'b0;
    rf_wdata_s  = alu_r;
    case (phase_r)
      FETCH:   phase_nxt_s = DECODE;
      DECODE:  phase_nxt_s = EXECUTE;
      EXECUTE: phase_nxt_s = MEM;
      MEM:     phase_nxt_s = WB;
      WB:      phase_nxt_s = (op_s == OP_HALT) ? HALT : FETCH;
      HALT:    phase_nxt_s = HALT;
      default: phase_nxt_s = FETCH;
    endcase
    case (op_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LDI, OP_IN: rf_we_s = 1'b1;
      OP_LD: begin
        rf_we_s    = 1'b1;
        rf_wdata_s = mdr_r;
      end
      OP_BEQ: begin
        if (d_r == a_r) pc_nxt_s = pc_r + PW'(1) + PW'(sext6(ir_r[5:0]));
        else            pc_nxt_s = pc_r + PW'(1);
      end
      OP_JMP:  pc_nxt_s = PW'(ir_r[11:0]);
      default: rf_we_s = 1'b0;
    endcase
    rf_we_s = rf_we_s & (rd_s != 3'd0);
  end

  // Architectural state and per-phase pipeline latches
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      phase_r <= FETCH;
      pc_r    <= {PW{1'b0}};
      ir_r    <= 16'h0000;
      a_r     <= 16'h0000;
      b_r     <= 16'h0000;
      d_r     <= 16'h0000;
      alu_r   <= 16'h0000;
      mdr_r   <= 16'h0000;
      dout_r  <= 16'h0000;
      for (int i = 0; i < 8; i++) rf_r[i] <= 16'h0000;
    end else begin
      phase_r <= phase_nxt_s;
      case (phase_r)
        FETCH:  ir_r <= prog_mem[pc_r];
        DECODE: begin
          a_r <= rf_r[rs_s];
          b_r <= rf_r[rt_s];
          d_r <= rf_r[rd_s];
        end
        EXECUTE: alu_r <= (op_s == OP_IN) ? din : alu_y_s;
        MEM:     mdr_r <= data_mem[addr_s];
        WB: begin
          pc_r <= pc_nxt_s;
          if (rf_we_s) rf_r[rd_s] <= rf_wdata_s;
          if (op_s == OP_OUT) dout_r <= a_r;
        end
        default: ir_r <= ir_r;
      endcase
    end
  end

  // Store port; reset aborts an in-flight ST before its MEM edge
  always_ff @(posedge clk) begin
    if (sys_rst && phase_r == MEM && op_s == OP_ST) data_mem[addr_s] <= d_r;
  end

endmodule

// File: tb/tb_cpu_top.sv
// Directed self-checking bench for cpu_top: memory access, arithmetic,
// load/store, branching loop and reset during execution.
module tb_cpu_top;
  import cpu_pkg::*;

  logic        clk;
  logic        sys_rst;
  logic [15:0] din;
  logic [15:0] dout;
  logic [15:0] prog [8];
  int          checks;
  int          passed;

  cpu_top dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .din     (din),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.prog_mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) dut.prog_mem[i] = prog[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic regs_zero;
    sys_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    regs_zero = 1'b1;
    for (int i = 0; i < 8; i++) if (dut.rf_r[i] !== 16'h0000) regs_zero = 1'b0;
    checks++;
    if (dout !== 16'h0000) $display("FAIL reset_dout: got %h expected 0000", dout);
    else passed++;
    checks++;
    if (dut.pc_r !== 8'h00) $display("FAIL reset_pc: got %h expected 00", dut.pc_r);
    else passed++;
    checks++;
    if (dut.phase_r !== FETCH) $display("FAIL reset_phase: got %0d expected %0d", dut.phase_r, FETCH);
    else passed++;
    checks++;
    if (regs_zero !== 1'b1) $display("FAIL reset_regs: got %b expected 1", regs_zero);
    else passed++;
  endtask

  task automatic test_mem_access();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      dut.data_mem[i] = 16'(i * 10);
      #10;
      checks++;
      if (dut.data_mem[i] !== 16'(i * 10))
        $display("FAIL mem_rw[%0d]: got %h expected %h", i, dut.data_mem[i], 16'(i * 10));
      else passed++;
    end
  endtask

  task automatic test_add_out();
    prog = '{16'h7205, 16'h7407, 16'h1650, 16'hB0C0, 16'hE000, 16'h0000, 16'h0000, 16'h0000};
    load_prog();
    do_reset();
    run(19);
    checks++;
    if (dout !== 16'h0000) $display("FAIL add_early: got %h expected 0000", dout);
    else passed++;
    run(1);
    checks++;
    if (dout !== 16'h000C) $display("FAIL add_out: got %h expected 000c", dout);
    else passed++;
    checks++;
    if (dut.rf_r[3] !== 16'h000C) $display("FAIL add_r3: got %h expected 000c", dut.rf_r[3]);
    else passed++;
    run(100);
    checks++;
    if (dout !== 16'h000C) $display("FAIL halt_hold: got %h expected 000c", dout);
    else passed++;
    checks++;
    if (dut.phase_r !== HALT) $display("FAIL halt_phase: got %0d expected %0d", dut.phase_r, HALT);
    else passed++;
  endtask

  task automatic test_in_wrap();
    prog = '{16'hA200, 16'hB040, 16'h6241, 16'hB040, 16'hE000, 16'h0000, 16'h0000, 16'h0000};
    load_prog();
    din = 16'hFFFF;
    do_reset();
    run(3);
    din = 16'h0000;
    run(2);
    checks++;
    if (dut.rf_r[1] !== 16'hFFFF) $display("FAIL in_sample: got %h expected ffff", dut.rf_r[1]);
    else passed++;
    run(5);
    checks++;
    if (dout !== 16'hFFFF) $display("FAIL in_out: got %h expected ffff", dout);
    else passed++;
    run(10);
    checks++;
    if (dout !== 16'h0000) $display("FAIL addi_wrap: got %h expected 0000", dout);
    else passed++;
  endtask

  task automatic test_load_store();
    prog = '{16'h7203, 16'h8440, 16'h6481, 16'h9441, 16'hE000, 16'h0000, 16'h0000, 16'h0000};
    load_prog();
    dut.data_mem[3] = 16'h1234;
    dut.data_mem[4] = 16'h0000;
    do_reset();
    run(18);
    checks++;
    if (dut.data_mem[4] !== 16'h0000) $display("FAIL st_early: got %h expected 0000", dut.data_mem[4]);
    else passed++;
    run(1);
    checks++;
    if (dut.data_mem[4] !== 16'h1235) $display("FAIL st_data: got %h expected 1235", dut.data_mem[4]);
    else passed++;
    checks++;
    if (dut.data_mem[3] !== 16'h1234) $display("FAIL ld_src: got %h expected 1234", dut.data_mem[3]);
    else passed++;
  endtask

  task automatic test_loop();
    prog = '{16'h7200, 16'h7403, 16'h6241, 16'hC281, 16'hD002, 16'hB040, 16'hE000, 16'h0000};
    load_prog();
    do_reset();
    run(54);
    checks++;
    if (dout !== 16'h0000) $display("FAIL loop_early: got %h expected 0000", dout);
    else passed++;
    run(1);
    checks++;
    if (dout !== 16'h0003) $display("FAIL loop_out: got %h expected 0003", dout);
    else passed++;
    run(10);
    checks++;
    if (dut.phase_r !== HALT) $display("FAIL loop_halt: got %0d expected %0d", dut.phase_r, HALT);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    prog = '{16'h7205, 16'h7407, 16'h1650, 16'hB0C0, 16'hE000, 16'h0000, 16'h0000, 16'h0000};
    load_prog();
    do_reset();
    run(13);
    checks++;
    if (dut.rf_r[2] !== 16'h0007) $display("FAIL pre_rst_r2: got %h expected 0007", dut.rf_r[2]);
    else passed++;
    sys_rst = 1'b0;
    #1;
    checks++;
    if (dut.pc_r !== 8'h00) $display("FAIL mid_rst_pc: got %h expected 00", dut.pc_r);
    else passed++;
    checks++;
    if (dut.rf_r[1] !== 16'h0000 || dut.rf_r[2] !== 16'h0000)
      $display("FAIL mid_rst_regs: got %h/%h expected 0000/0000", dut.rf_r[1], dut.rf_r[2]);
    else passed++;
    checks++;
    if (dout !== 16'h0000) $display("FAIL mid_rst_dout: got %h expected 0000", dout);
    else passed++;
    do_reset();
    run(20);
    checks++;
    if (dout !== 16'h000C) $display("FAIL rerun_out: got %h expected 000c", dout);
    else passed++;
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    sys_rst = 1'b0;
    din     = 16'h0000;
    prog    = '{default: 16'h0000};
    test_reset();
    test_mem_access();
    test_add_out();
    test_in_wrap();
    test_load_store();
    test_loop();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
